uart_tx_periph: RTL and testbench

- Memory-mapped UART transmitter on the core data bus, alongside the data RAM.
- Consumes the core's write/read address, write data and write enable; the core reads back over a read-data mux.
- Buffers bytes in a small FIFO and serialises them 8N1 on tx_o using a programmable baud divider.
- Lets firmware print without stalling the core.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/uart_tx_periph.sv | 192 +++++++++++++++++++
 tb/tb_uart_tx_periph.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, transmit FSM encoding and the divider floor.
package uart_pkg;

   // Register offsets, selected by addr[3:2]
   localparam logic [1:0] UART_TXDATA = 2'd0;
   localparam logic [1:0] UART_STATUS = 2'd1;
   localparam logic [1:0] UART_BAUD   = 2'd2;

   // STATUS bit positions
   localparam int STAT_FULL    = 0;
   localparam int STAT_EMPTY   = 1;
   localparam int STAT_ACTIVE  = 2;
   localparam int STAT_OVF     = 3;
   localparam int STAT_CNT_LSB = 8;
   localparam int STAT_CNT_W   = 4;

   // Smallest divider the bit timer can handle without a wrap hazard
   localparam logic [15:0] MIN_DIV = 16'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

   // Raise divider values below the floor to the floor
   function automatic logic [15:0] clamp_div(input logic [15:0] v);
      return (v < MIN_DIV) ? MIN_DIV : v;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with occupancy count. The head entry is presented
// combinationally so the consumer can take it on the same edge it pops.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // Requests are ignored when they cannot be honoured (push full / pop empty)
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // Next pointer and occupancy values
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers; storage contents are simply abandoned on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage write port
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: bus decode, control/status registers,
// TX FIFO and the serialising FSM. Firmware pushes bytes and carries on; the
// FSM drains the FIFO back-to-back at the latched divider rate.
module uart_tx_periph
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_we_i,
   input  logic [31:0] mem_waddr_i,
   input  logic [31:0] mem_wdata_i,
   input  logic [31:0] mem_raddr_i,
   output logic [31:0] mem_rdata_o,
   output logic        tx_o,
   output logic        busy_o
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   // Bus decode
   logic       wr_hit, rd_hit;
   logic [1:0] wr_off;
   logic       push_req, status_wr, baud_wr;

   assign wr_hit    = (mem_waddr_i[31:12] == BASE_ADDR[31:12]);
   assign rd_hit    = (mem_raddr_i[31:12] == BASE_ADDR[31:12]);
   assign wr_off    = mem_waddr_i[3:2];
   assign push_req  = mem_we_i & wr_hit & (wr_off == UART_TXDATA);
   assign status_wr = mem_we_i & wr_hit & (wr_off == UART_STATUS);
   assign baud_wr   = mem_we_i & wr_hit & (wr_off == UART_BAUD);

   // FIFO
   logic [7:0]    fifo_head;
   logic          fifo_full, fifo_empty, fifo_pop;
   logic [CW-1:0] fifo_count;
   logic [31:0]   cnt_ext;

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_req & ~fifo_full),
      .pop_i   (fifo_pop),
      .wdata_i (mem_wdata_i[7:0]),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign cnt_ext = 32'(fifo_count);

   // Registers and FSM state
   logic        ovf_q, ovf_d;
   logic [15:0] baud_div_q, baud_div_d;
   tx_state_e   state_q, state_d;
   logic [15:0] bit_cnt_q, bit_cnt_d;
   logic [15:0] bit_div_q, bit_div_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        tx_q, tx_d;
   logic        bit_end;

   assign bit_end = (bit_cnt_q == bit_div_q - 16'd1);

   // Sticky overflow flag (a dropped push sets it, W1C on STATUS bit3) and divider
   always_comb begin
      ovf_d      = ovf_q;
      baud_div_d = baud_div_q;
      if (push_req && fifo_full)                   ovf_d = 1'b1;
      else if (status_wr && mem_wdata_i[STAT_OVF]) ovf_d = 1'b0;
      if (baud_wr) baud_div_d = clamp_div(mem_wdata_i[15:0]);
   end

   // Transmit FSM: a frame loads from the FIFO head in IDLE or at the end of STOP
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      bit_div_d = bit_div_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      fifo_pop  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               shift_d   = fifo_head;
               bit_div_d = baud_div_q;
               bit_cnt_d = '0;
               state_d   = ST_START;
            end
         end
         ST_START: begin
            if (bit_end) begin
               bit_cnt_d = '0;
               bit_idx_d = '0;
               state_d   = ST_DATA;
            end else begin
               bit_cnt_d = bit_cnt_q + 16'd1;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               bit_cnt_d = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
               end
            end else begin
               bit_cnt_d = bit_cnt_q + 16'd1;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               bit_cnt_d = '0;
               if (!fifo_empty) begin
                  fifo_pop  = 1'b1;
                  shift_d   = fifo_head;
                  bit_div_d = baud_div_q;
                  state_d   = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Line level follows the state being entered, so tx_o is glitch-free
      case (state_d)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = shift_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   // State registers; reset forces the line back to idle-high immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q      <= 1'b0;
         baud_div_q <= clamp_div(DEFAULT_DIV);
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         bit_div_q  <= MIN_DIV;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
      end else begin
         ovf_q      <= ovf_d;
         baud_div_q <= baud_div_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         bit_div_q  <= bit_div_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
      end
   end

   assign tx_o   = tx_q;
   assign busy_o = (state_q != ST_IDLE) | ~fifo_empty;

   // Side-effect-free read mux
   always_comb begin
      mem_rdata_o = '0;
      if (rd_hit) begin
         case (mem_raddr_i[3:2])
            UART_STATUS: begin
               mem_rdata_o[STAT_FULL]   = fifo_full;
               mem_rdata_o[STAT_EMPTY]  = fifo_empty;
               mem_rdata_o[STAT_ACTIVE] = (state_q != ST_IDLE);
               mem_rdata_o[STAT_OVF]    = ovf_q;
               mem_rdata_o[STAT_CNT_LSB +: STAT_CNT_W] = cnt_ext[STAT_CNT_W-1:0];
            end
            UART_BAUD: mem_rdata_o[15:0] = baud_div_q;
            default:   mem_rdata_o = '0;
         endcase
      end
   end

   // Address/data bits that the register map does not decode
   logic unused_bits;
   assign unused_bits = ^{mem_waddr_i[11:4], mem_waddr_i[1:0], mem_raddr_i[11:4],
                          mem_raddr_i[1:0], mem_wdata_i[31:16], cnt_ext[31:STAT_CNT_W]};

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph: register map, framing, back-to-back,
// overflow, divider clamp/latching, decode misses and asynchronous reset.
module tb_uart_tx_periph;

   localparam logic [31:0] A_TXDATA = 32'h3000_0000;
   localparam logic [31:0] A_STATUS = 32'h3000_0004;
   localparam logic [31:0] A_BAUD   = 32'h3000_0008;
   localparam logic [31:0] A_RSVD   = 32'h3000_000C;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_we_i;
   logic [31:0] mem_waddr_i, mem_wdata_i, mem_raddr_i;
   logic [31:0] mem_rdata_o;
   logic        tx_o, busy_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   uart_tx_periph #(
      .BASE_ADDR   (32'h3000_0000),
      .FIFO_DEPTH  (8),
      .DEFAULT_DIV (16'd434)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem_we_i    (mem_we_i),
      .mem_waddr_i (mem_waddr_i),
      .mem_wdata_i (mem_wdata_i),
      .mem_raddr_i (mem_raddr_i),
      .mem_rdata_o (mem_rdata_o),
      .tx_o        (tx_o),
      .busy_o      (busy_o)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, got);
      end
   endtask

   // One bus write: occupies exactly the next rising edge
   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
      mem_waddr_i = addr;
      mem_wdata_i = data;
      mem_we_i    = 1'b1;
      @(posedge clk);
      #1;
      mem_we_i = 1'b0;
      $display("wr   addr=0x%08h data=0x%08h", addr, data);
   endtask

   task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      mem_raddr_i = addr;
      #1;
      check_val(tag, mem_rdata_o, exp);
   endtask

   // Checks one frame whose first cycle begins at the next rising edge
   task automatic check_frame(input string tag, input logic [7:0] b, input int div);
      logic [9:0] exp_bits;
      logic [9:0] obs;
      int bad;
      int idle;
      exp_bits = {1'b1, b, 1'b0};
      obs  = '0;
      bad  = 0;
      idle = 0;
      @(posedge clk);
      for (int c = 0; c < 10 * div; c++) begin
         @(negedge clk);
         if (tx_o !== exp_bits[c / div]) bad++;
         if (busy_o !== 1'b1) idle++;
         if ((c % div) == (div / 2)) obs[c / div] = tx_o;
      end
      check_val({tag, "_bits"},  {22'd0, obs}, {22'd0, exp_bits});
      check_val({tag, "_shape"}, bad,  0);
      check_val({tag, "_busy"},  idle, 0);
   endtask

   task automatic check_idle(input string tag);
      @(posedge clk);
      #1;
      check_val({tag, "_idle_tx"},   {31'd0, tx_o},   32'd1);
      check_val({tag, "_idle_busy"}, {31'd0, busy_o}, 32'd0);
      read_check({tag, "_idle_status"}, A_STATUS, 32'h0000_0002);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      mem_we_i    = 1'b0;
      mem_waddr_i = '0;
      mem_wdata_i = '0;
      mem_raddr_i = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_tx",   {31'd0, tx_o},   32'd1);
      check_val("rst_busy", {31'd0, busy_o}, 32'd0);
      read_check("rst_status", A_STATUS, 32'h0000_0002);
      read_check("rst_baud",   A_BAUD,   32'd434);
      read_check("rst_txdata", A_TXDATA, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      read_check("post_rst_status", A_STATUS, 32'h0000_0002);

      // Divider clamp
      bus_write(A_BAUD, 32'd1);
      read_check("baud_clamp1", A_BAUD, 32'd2);
      bus_write(A_BAUD, 32'd0);
      read_check("baud_clamp0", A_BAUD, 32'd2);
      bus_write(A_BAUD, 32'h0001_0004);
      read_check("baud_4", A_BAUD, 32'd4);

      // Single byte: line still idle before the pop edge, FIFO holds one entry
      bus_write(A_TXDATA, 32'h0000_00A5);
      check_val("pre_pop_tx",   {31'd0, tx_o},   32'd1);
      check_val("pre_pop_busy", {31'd0, busy_o}, 32'd1);
      read_check("pre_pop_status", A_STATUS, 32'h0000_0100);
      check_frame("a5", 8'hA5, 4);
      check_idle("a5");

      // Back-to-back frames with no gap
      bus_write(A_TXDATA, 32'h0000_0001);
      fork
         begin
            bus_write(A_TXDATA, 32'h0000_0002);
            bus_write(A_TXDATA, 32'h0000_0003);
            read_check("b2b_status", A_STATUS, 32'h0000_0204);
         end
         begin
            check_frame("b2b_01", 8'h01, 4);
            check_frame("b2b_02", 8'h02, 4);
            check_frame("b2b_03", 8'h03, 4);
         end
      join
      check_idle("b2b");

      // Divider change mid-frame only affects the next frame
      bus_write(A_TXDATA, 32'h0000_003C);
      fork
         begin
            bus_write(A_TXDATA, 32'h0000_00C3);
            repeat (10) @(posedge clk);
            #1;
            bus_write(A_BAUD, 32'd8);
         end
         begin
            check_frame("div4", 8'h3C, 4);
            check_frame("div8", 8'hC3, 8);
         end
      join
      read_check("baud_8", A_BAUD, 32'd8);
      check_idle("divchg");

      // Decode misses
      bus_write(32'h3000_1000, 32'h0000_0055);
      bus_write(32'h2000_0008, 32'h0000_0005);
      bus_write(A_RSVD,        32'h0000_00FF);
      repeat (3) @(posedge clk);
      #1;
      check_val("miss_tx", {31'd0, tx_o}, 32'd1);
      read_check("miss_status", A_STATUS, 32'h0000_0002);
      read_check("miss_baud",   A_BAUD,   32'd8);
      read_check("miss_read",   32'h2000_0004, 32'd0);
      read_check("miss_alias",  32'h3000_1008, 32'd0);
      read_check("rsvd_read",   A_RSVD,   32'd0);

      // Overflow: one in flight, eight buffered, tenth dropped
      bus_write(A_BAUD, 32'd100);
      for (int i = 0; i < 10; i++) bus_write(A_TXDATA, 32'(i));
      read_check("ovf_status", A_STATUS, 32'h0000_080D);
      bus_write(A_STATUS, 32'h0000_0008);
      read_check("ovf_clear", A_STATUS, 32'h0000_0805);

      // Asynchronous reset in the middle of a data bit of 0x00
      repeat (150) @(posedge clk);
      @(negedge clk);
      check_val("mid_data_tx", {31'd0, tx_o}, 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("async_rst_tx",   {31'd0, tx_o},   32'd1);
      check_val("async_rst_busy", {31'd0, busy_o}, 32'd0);
      read_check("async_rst_status", A_STATUS, 32'h0000_0002);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_val("rel_tx", {31'd0, tx_o}, 32'd1);
      read_check("rel_status", A_STATUS, 32'h0000_0002);
      read_check("rel_baud",   A_BAUD,   32'd434);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
